// File: rtl/cachevictimbuf.sv
// cachevictimbuf: single-entry dirty-line eviction buffer that drains a captured victim line to the bus as valid/ready beats
module cachevictimbuf #(
  parameter int NUMWAYS   = 4,
  parameter int LINELEN   = 512,
  parameter int BEATW     = 64,
  parameter int PA_BITS   = 32,
  parameter int OFFSETLEN = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       Capture,
  input  logic [NUMWAYS-1:0]         VictimWay,
  input  logic [NUMWAYS-1:0]         DirtyWay,
  input  logic [NUMWAYS*LINELEN-1:0] ReadDataLineWay,
  input  logic [PA_BITS-1:0]         VictimAdr,
  input  logic [PA_BITS-1:0]         SnoopAdr,
  output logic                       Full,
  output logic                       SnoopHit,
  output logic                       BusValid,
  input  logic                       BusReady,
  output logic [PA_BITS-1:0]         BusAdr,
  output logic [BEATW-1:0]           BusData,
  output logic                       BusLast,
  output logic                       DrainDone
);
  localparam int NUMBEATS = LINELEN / BEATW;
  localparam int CW = $clog2(NUMBEATS);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_n;
  logic [LINELEN-1:0] line, sel;
  logic [CW-1:0] cnt;
  logic take, beat, unused_ofs;
  assign take = (state == IDLE) && Capture && |(VictimWay & DirtyWay);
  assign beat = (state == DRAIN) && BusReady;
  assign Full = (state == DRAIN);
  assign BusValid = Full;
  assign BusData = line[BEATW-1:0];
  // BusAdr never leaves the buffered line while draining, so its upper bits are the line tag
  assign SnoopHit = Full && (SnoopAdr[PA_BITS-1:OFFSETLEN] == BusAdr[PA_BITS-1:OFFSETLEN]);
  assign unused_ofs = ^{VictimAdr[OFFSETLEN-1:0], SnoopAdr[OFFSETLEN-1:0]};
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUMWAYS; i++)
      sel = sel | ({LINELEN{VictimWay[i]}} & ReadDataLineWay[i*LINELEN +: LINELEN]);
  end
  always_comb begin
    state_n = state;
    state_n = take ? DRAIN : (beat && BusLast) ? IDLE : state;
  end
  // the line register shifts down one beat per handshake, keeping the current beat at the bottom
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      line      <= '0;
      BusAdr    <= '0;
      cnt       <= '0;
      BusLast   <= 1'b0;
      DrainDone <= 1'b0;
    end else begin
      state     <= state_n;
      DrainDone <= beat && BusLast;
      if (take) begin
        line    <= sel;
        BusAdr  <= {VictimAdr[PA_BITS-1:OFFSETLEN], OFFSETLEN'(0)};
        cnt     <= '0;
        BusLast <= 1'b0;
      end else if (beat) begin
        line    <= line >> BEATW;
        BusAdr  <= BusAdr + PA_BITS'(BEATW / 8);
        cnt     <= cnt + CW'(1);
        BusLast <= (cnt == CW'(NUMBEATS - 2));
      end
    end
  end
endmodule

// File: tb/tb_cachevictimbuf.sv
// tb_cachevictimbuf: directed and random checks of cachevictimbuf against a beat-queue reference model
module tb_cachevictimbuf;
  localparam int NW = 4, LL = 512, BW = 64, PA = 32, OL = 6, NB = LL / BW;
  logic clk = 0, reset_n = 0, Capture = 0, BusReady = 0;
  logic [NW-1:0] VictimWay = '0, DirtyWay = '0;
  logic [NW*LL-1:0] ReadDataLineWay = '0;
  logic [PA-1:0] VictimAdr = '0, SnoopAdr = '0;
  logic Full, SnoopHit, BusValid, BusLast, DrainDone;
  logic [PA-1:0] BusAdr;
  logic [BW-1:0] BusData;
  int n_assert = 0, n_fail = 0, vcycles = 0, stall = 0, t = 0;
  logic [PA-1:0] qa[$];
  logic [BW-1:0] qd[$];
  logic [PA-1:0] m_base = '0;
  logic m_done = 0;

  cachevictimbuf dut (
    .clk(clk), .reset_n(reset_n), .Capture(Capture), .VictimWay(VictimWay), .DirtyWay(DirtyWay),
    .ReadDataLineWay(ReadDataLineWay), .VictimAdr(VictimAdr), .SnoopAdr(SnoopAdr), .Full(Full),
    .SnoopHit(SnoopHit), .BusValid(BusValid), .BusReady(BusReady), .BusAdr(BusAdr), .BusData(BusData),
    .BusLast(BusLast), .DrainDone(DrainDone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qd.delete();
    m_done = 0;
  endtask

  // advance the model across one rising edge using the inputs currently driven
  task automatic model_edge();
    logic idle;
    logic [LL-1:0] l;
    idle = (qa.size() == 0);
    m_done = 0;
    if (!idle && BusReady) begin
      m_done = (qa.size() == 1);
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    if (idle && Capture && |(VictimWay & DirtyWay)) begin
      l = '0;
      for (int w = 0; w < NW; w++) if (VictimWay[w]) l = l | ReadDataLineWay[w*LL +: LL];
      m_base = {VictimAdr[PA-1:OL], {OL{1'b0}}};
      for (int b = 0; b < NB; b++) begin
        qa.push_back(m_base + PA'(b * (BW / 8)));
        qd.push_back(l[b*BW +: BW]);
      end
    end
  endtask

  task automatic check_all();
    chk("model.valid", BusValid, qa.size() != 0);
    chk("model.full", Full, qa.size() != 0);
    chk("model.last", BusLast, qa.size() == 1);
    if (qa.size() != 0) begin
      chk("model.adr", BusAdr, qa[0]);
      chk("model.data", BusData, qd[0]);
    end
    chk("model.done", DrainDone, m_done);
    chk("model.snoop", SnoopHit, qa.size() != 0 && SnoopAdr[PA-1:OL] == m_base[PA-1:OL]);
  endtask

  task automatic cycle();
    model_edge();
    @(negedge clk);
    check_all();
    if (BusValid) vcycles++;
  endtask

  task automatic rand_data();
    for (int w = 0; w < NW * LL / 32; w++) ReadDataLineWay[w*32 +: 32] = $urandom();
  endtask

  task automatic load_a0();
    rand_data();
    for (int b = 0; b < NB; b++) ReadDataLineWay[2*LL + b*BW +: BW] = 64'hA0 + 64'(b);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, ".full"}, Full, 0);
    chk({tag, ".valid"}, BusValid, 0);
    chk({tag, ".last"}, BusLast, 0);
    chk({tag, ".done"}, DrainDone, 0);
    chk({tag, ".snoop"}, SnoopHit, 0);
    chk({tag, ".adr"}, BusAdr, 0);
    chk({tag, ".data"}, BusData, 0);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    reset_outputs_zero("rst");
    @(negedge clk);
    reset_n = 1;
    model_reset();
    cycle();
    cycle();
    chk("rst.idle_full", Full, 0);
    #2 reset_n = 0;
    #1 reset_outputs_zero("rst_mid");
    @(negedge clk);
    reset_n = 1;
    model_reset();
    // dirty capture with continuous ready
    load_a0();
    VictimWay = 4'b0100; DirtyWay = 4'b0100; VictimAdr = 32'h8000_1234; BusReady = 1; Capture = 1;
    cycle();
    Capture = 0;
    rand_data();
    VictimAdr = $urandom();
    for (int i = 0; i < NB; i++) begin
      if (i > 0) cycle();
      chk("dirty.adr", BusAdr, 32'h8000_1200 + 32'(8 * i));
      chk("dirty.data", BusData, 64'hA0 + 64'(i));
      chk("dirty.last", BusLast, i == NB - 1);
    end
    cycle();
    chk("dirty.done", DrainDone, 1);
    chk("dirty.full", Full, 0);
    cycle();
    chk("dirty.done_pulse", DrainDone, 0);
    // clean victim and empty victim way
    VictimWay = 4'b0001; DirtyWay = 4'b1110; Capture = 1;
    cycle();
    cycle();
    chk("clean.full", Full, 0);
    chk("clean.valid", BusValid, 0);
    VictimWay = 4'b0000; DirtyWay = 4'b1111;
    cycle();
    cycle();
    chk("noway.full", Full, 0);
    Capture = 0;
    // backpressure on beat 2
    load_a0();
    VictimWay = 4'b0100; DirtyWay = 4'b0100; VictimAdr = 32'h8000_1200; BusReady = 1; Capture = 1;
    vcycles = 0;
    cycle();
    Capture = 0;
    t = 0; stall = 0;
    while (BusValid && t < 40) begin
      if (qa.size() == NB - 2 && stall < 3) begin BusReady = 0; stall++; end
      else BusReady = 1;
      cycle();
      t++;
      if (!BusReady) begin
        chk("bp.hold_valid", BusValid, 1);
        chk("bp.hold_adr", BusAdr, 32'h8000_1210);
        chk("bp.hold_data", BusData, 64'hA2);
      end
    end
    chk("bp.len", vcycles, 11);
    // snoop hits and a capture held across the final handshake
    BusReady = 1;
    load_a0();
    VictimAdr = 32'h8000_1200; Capture = 1;
    cycle();
    Capture = 0;
    SnoopAdr = 32'h8000_123C;
    cycle();
    chk("snoop.hit", SnoopHit, 1);
    SnoopAdr = 32'h8000_1240;
    cycle();
    chk("snoop.miss", SnoopHit, 0);
    t = 0;
    while (!BusLast && t < 20) begin cycle(); t++; end
    chk("blk.last_seen", BusLast, 1);
    rand_data();
    VictimWay = 4'b1000; DirtyWay = 4'b1000; VictimAdr = 32'h4000_0080; Capture = 1;
    cycle();
    chk("blk.ignored_full", Full, 0);
    chk("blk.done", DrainDone, 1);
    cycle();
    chk("blk.accepted_full", Full, 1);
    chk("blk.accepted_adr", BusAdr, 32'h4000_0080);
    Capture = 0;
    // reset after beat 3 accepted
    for (int i = 0; i < 4; i++) cycle();
    chk("rdrain.beats_left", qa.size(), NB - 4);
    #2 reset_n = 0;
    #1 reset_outputs_zero("rdrain");
    model_reset();
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk("rdrain.no_beats", BusValid, 0);
    rand_data();
    VictimWay = 4'b0010; DirtyWay = 4'b0011; VictimAdr = 32'h1234_5678; Capture = 1;
    cycle();
    Capture = 0;
    chk("rdrain.recapture", Full, 1);
    chk("rdrain.recapture_adr", BusAdr, 32'h1234_5640);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      Capture = ($urandom_range(0, 1) == 1);
      VictimWay = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, NW - 1));
      DirtyWay = 4'($urandom());
      VictimAdr = $urandom();
      SnoopAdr = ($urandom_range(0, 1) == 1) ? (m_base | 32'($urandom_range(0, 63))) : $urandom();
      BusReady = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) rand_data();
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
